// File: rtl/irq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_ctrl_if                                                  |
// | Description : Core-facing bus and interrupt handshake for irq_ctrl.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface irq_ctrl_if;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;

  modport master (
    input  interrupt_vector, bus_read_data,
    output interrupt_ack, bus_address, bus_write_data, bus_write_enable, bus_read_enable
  );

  modport slave (
    output interrupt_vector, bus_read_data,
    input  interrupt_ack, bus_address, bus_write_data, bus_write_enable, bus_read_enable
  );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : irq_ctrl                                                     |
// | Description : Bus-mapped external interrupt controller, fixed priority.    |
// |               IRQ_LEVEL_EN selects level-tracking pending (default: edge). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module irq_ctrl #(
  parameter int          NUM_SRC     = 4,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0C00_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  irq_ctrl_if.slave          bus
);

  localparam logic [1:0] c_OFF_PENDING  = 2'd0;
  localparam logic [1:0] c_OFF_ENABLE   = 2'd1;
  localparam logic [1:0] c_OFF_CLAIM    = 2'd2;
  localparam logic [1:0] c_OFF_COMPLETE = 2'd3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SERVICE = 2'd2} state_t;

  state_t             r_state;
  logic [3:0]         r_vector;
  logic [3:0]         r_in_service;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [63:0]        r_rdata;
  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];

  logic               w_hit;
  logic [1:0]         w_off;
  logic               w_wr;
  logic               w_en_wr;
  logic               w_complete;
  logic [NUM_SRC-1:0] w_level;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_cur_mask;
  logic               w_cur_live;
  logic               w_claim;
  logic [3:0]         w_winner_id;
  logic [63:0]        w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_level    = r_sync[SYNC_STAGES-1];
  assign w_hit      = (bus.bus_address[63:5] == BASE_ADDR[63:5]) && (bus.bus_address[2:0] == 3'b000);
  assign w_off      = bus.bus_address[4:3];
  assign w_wr       = bus.bus_write_enable && w_hit;
  assign w_en_wr    = w_wr && (w_off == c_OFF_ENABLE);
  assign w_complete = w_wr && (w_off == c_OFF_COMPLETE) && (r_state == ST_SERVICE)
                      && (bus.bus_write_data == {60'd0, r_in_service});

  assign w_active   = r_pending & r_enable;
  // Mask of the source currently presented on the vector; only meaningful in REQ.
  assign w_cur_mask = NUM_SRC'(1) << (r_vector - 4'd1);
  assign w_cur_live = |(w_active & w_cur_mask);
  assign w_claim    = (r_state == ST_REQ) && w_cur_live && bus.interrupt_ack;

  always_comb begin
    w_winner_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_winner_id = 4'(i + 1);
    end
  end

`ifdef IRQ_LEVEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_level;
  end
`else
  logic [NUM_SRC-1:0] r_level_q;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_claim_mask;

  assign w_rise       = w_level & ~r_level_q;
  assign w_w1c        = (w_wr && (w_off == c_OFF_PENDING)) ? bus.bus_write_data[NUM_SRC-1:0] : '0;
  assign w_claim_mask = w_claim ? w_cur_mask : '0;

  // A fresh edge is OR-ed in after the clears so a coincident set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_q <= '0;
      r_pending <= '0;
    end else begin
      r_level_q <= w_level;
      r_pending <= (r_pending & ~w_w1c & ~w_claim_mask) | w_rise;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_enable <= '0;
    else if (w_en_wr) r_enable <= bus.bus_write_data[NUM_SRC-1:0];
  end

  always_comb begin
    w_rdata = 64'd0;
    if (w_hit) begin
      case (w_off)
        c_OFF_PENDING: w_rdata = 64'(r_pending);
        c_OFF_ENABLE:  w_rdata = 64'(r_enable);
        c_OFF_CLAIM:   w_rdata = 64'(r_in_service);
        default:       w_rdata = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_rdata <= 64'd0;
    else if (bus.bus_read_enable) r_rdata <= w_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_vector     <= 4'd0;
      r_in_service <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_active) begin
            r_vector <= w_winner_id;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!w_cur_live) begin
            r_vector <= 4'd0;
            r_state  <= ST_IDLE;
          end else if (bus.interrupt_ack) begin
            r_in_service <= r_vector;
            r_vector     <= 4'd0;
            r_state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (w_complete) begin
            r_in_service <= 4'd0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_vector <= 4'd0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.interrupt_vector = r_vector;
  assign bus.bus_read_data    = r_rdata;

endmodule
`default_nettype wire
